// File: rtl/sync_fifo_ptr_ctrl.sv
// ---------------------------------------------------------------------------
// sync_fifo_ptr_ctrl
//
// Pointer and status controller for a single-clock FIFO.
// The data storage lives outside this block. This block owns the read and
// write pointers, the occupancy count, and the status and error flags.
// It also exports Gray-coded copies of both pointers, so that another clock
// domain can sample them safely.
//
// Parameters
//   ADDR_WIDTH : RAM address bits; DEPTH = 2**ADDR_WIDTH entries
//   AF_THRESH  : almost_full asserts when occupancy >= AF_THRESH
//   AE_THRESH  : almost_empty asserts when occupancy <= AE_THRESH
//
// Ports
//   clk           : single clock, all state on the rising edge
//   rst_n         : asynchronous active-low reset
//   clr           : synchronous clear of all state (overrides wr_en/rd_en)
//   wr_en, rd_en  : write / read requests
//   wr_addr       : RAM write address (low bits of the binary write pointer)
//   rd_addr       : RAM read address (low bits of the binary read pointer)
//   wr_gray       : Gray-coded write pointer, ADDR_WIDTH+1 bits
//   rd_gray       : Gray-coded read pointer, ADDR_WIDTH+1 bits
//   count         : occupancy, 0..DEPTH
//   full, empty   : registered status flags
//   almost_full   : registered threshold flag
//   almost_empty  : registered threshold flag
//   overflow      : sticky; write attempted while full
//   underflow     : sticky; read attempted while empty
//   wr_ack, rd_ack: one-cycle pulse after each accepted write / read
// ---------------------------------------------------------------------------
module sync_fifo_ptr_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = 14,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH:0]   wr_gray,
  output logic [ADDR_WIDTH:0]   rd_gray,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  wr_ack,
  output logic                  rd_ack
);

  // Pointers carry one extra wrap bit beyond the address.
  // This extra bit lets full and empty be told apart when the addresses match.
  localparam int PW = ADDR_WIDTH + 1;

  localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_LVL = PW'(AE_THRESH);
  // With a zero almost-full level, an empty FIFO is already "almost full".
  localparam logic          AF_RST = (AF_THRESH == 0);

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  logic [PW-1:0] wr_bin_reg,  wr_bin_next;
  logic [PW-1:0] rd_bin_reg,  rd_bin_next;
  logic [PW-1:0] wr_gray_reg, wr_gray_next;
  logic [PW-1:0] rd_gray_reg, rd_gray_next;
  logic [PW-1:0] count_reg,   count_next;
  logic          full_reg,    full_next;
  logic          empty_reg,   empty_next;
  logic          af_reg,      af_next;
  logic          ae_reg,      ae_next;
  logic          ovf_reg,     ovf_next;
  logic          udf_reg,     udf_next;
  logic          wr_ack_reg,  wr_ack_next;
  logic          rd_ack_reg,  rd_ack_next;

  logic          wr_accept;
  logic          rd_accept;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // Acceptance uses the flags already registered for this cycle.
    // Because of this, wr_en and rd_en never reach an output combinationally.
    // When the FIFO is full, a simultaneous read is still accepted; the write
    // is not. When it is empty, the write is accepted and the read is not.
    wr_accept    = wr_en & ~full_reg;
    rd_accept    = rd_en & ~empty_reg;

    wr_bin_next  = wr_bin_reg + {{ADDR_WIDTH{1'b0}}, wr_accept};
    rd_bin_next  = rd_bin_reg + {{ADDR_WIDTH{1'b0}}, rd_accept};

    // Gray code is derived from the next binary value.
    // This keeps it on the same edge as the binary pointer.
    // It changes one bit per increment, including at the wrap from all-ones to zero.
    wr_gray_next = wr_bin_next ^ (wr_bin_next >> 1);
    rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1);

    // Modular subtraction gives the correct occupancy across pointer wrap.
    count_next   = wr_bin_next - rd_bin_next;

    full_next    = (wr_bin_next[PW-1] != rd_bin_next[PW-1]) &&
                   (wr_bin_next[PW-2:0] == rd_bin_next[PW-2:0]);
    empty_next   = (wr_bin_next == rd_bin_next);
    af_next      = (count_next >= AF_LVL);
    ae_next      = (count_next <= AE_LVL);

    // Sticky error flags: once set, they stay set until clr or reset.
    ovf_next     = ovf_reg | (wr_en & full_reg);
    udf_next     = udf_reg | (rd_en & empty_reg);

    wr_ack_next  = wr_accept;
    rd_ack_next  = rd_accept;
  end

  // -------------------------------------------------------------------------
  // Sequential state
  // clr loads exactly the same values as the asynchronous reset.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bin_reg  <= '0;
      rd_bin_reg  <= '0;
      wr_gray_reg <= '0;
      rd_gray_reg <= '0;
      count_reg   <= '0;
      full_reg    <= 1'b0;
      empty_reg   <= 1'b1;
      af_reg      <= AF_RST;
      ae_reg      <= 1'b1;
      ovf_reg     <= 1'b0;
      udf_reg     <= 1'b0;
      wr_ack_reg  <= 1'b0;
      rd_ack_reg  <= 1'b0;
    end else if (clr) begin
      wr_bin_reg  <= '0;
      rd_bin_reg  <= '0;
      wr_gray_reg <= '0;
      rd_gray_reg <= '0;
      count_reg   <= '0;
      full_reg    <= 1'b0;
      empty_reg   <= 1'b1;
      af_reg      <= AF_RST;
      ae_reg      <= 1'b1;
      ovf_reg     <= 1'b0;
      udf_reg     <= 1'b0;
      wr_ack_reg  <= 1'b0;
      rd_ack_reg  <= 1'b0;
    end else begin
      wr_bin_reg  <= wr_bin_next;
      rd_bin_reg  <= rd_bin_next;
      wr_gray_reg <= wr_gray_next;
      rd_gray_reg <= rd_gray_next;
      count_reg   <= count_next;
      full_reg    <= full_next;
      empty_reg   <= empty_next;
      af_reg      <= af_next;
      ae_reg      <= ae_next;
      ovf_reg     <= ovf_next;
      udf_reg     <= udf_next;
      wr_ack_reg  <= wr_ack_next;
      rd_ack_reg  <= rd_ack_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: every output is driven directly from a register.
  // -------------------------------------------------------------------------
  assign wr_addr      = wr_bin_reg[PW-2:0];
  assign rd_addr      = rd_bin_reg[PW-2:0];
  assign wr_gray      = wr_gray_reg;
  assign rd_gray      = rd_gray_reg;
  assign count        = count_reg;
  assign full         = full_reg;
  assign empty        = empty_reg;
  assign almost_full  = af_reg;
  assign almost_empty = ae_reg;
  assign overflow     = ovf_reg;
  assign underflow    = udf_reg;
  assign wr_ack       = wr_ack_reg;
  assign rd_ack       = rd_ack_reg;

endmodule

// File: doc/sync_fifo_ptr_ctrl.md
SYNC_FIFO_PTR_CTRL -- requirements
Module: sync_fifo_ptr_ctrl

Interface
REQ-001 The parameter list SHALL be: ADDR_WIDTH, default 4, address bits; DEPTH = 2**ADDR_WIDTH entries.
REQ-002 The parameter list SHALL include AF_THRESH, default 14, almost-full level in entries; legal range AE_THRESH < AF_THRESH <= DEPTH.
REQ-003 The parameter list SHALL include AE_THRESH, default 2, almost-empty level in entries; legal range 0 <= AE_THRESH < AF_THRESH.
REQ-004 The module SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-005 The module SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 The module SHALL have port clr, input, 1, synchronous clear of all state.
REQ-007 The module SHALL have port wr_en, input, 1, write request.
REQ-008 The module SHALL have port rd_en, input, 1, read request.
REQ-009 The module SHALL have port wr_addr, output, ADDR_WIDTH, RAM write address (wr_bin[ADDR_WIDTH-1:0]).
REQ-010 The module SHALL have port rd_addr, output, ADDR_WIDTH, RAM read address (rd_bin[ADDR_WIDTH-1:0]).
REQ-011 The module SHALL have port wr_gray, output, ADDR_WIDTH+1, Gray-coded write pointer for export to another domain.
REQ-012 The module SHALL have port rd_gray, output, ADDR_WIDTH+1, Gray-coded read pointer for export to another domain.
REQ-013 The module SHALL have port count, output, ADDR_WIDTH+1, occupancy, 0..DEPTH.
REQ-014 The module SHALL have ports full, empty, almost_full and almost_empty, each output, 1, registered status flags.
REQ-015 The module SHALL have ports overflow and underflow, each output, 1, sticky error flags.
REQ-016 The module SHALL have ports wr_ack and rd_ack, each output, 1, one-cycle registered pulse per accepted write/read.

Function
REQ-017 The block SHALL hold internal binary pointers wr_bin and rd_bin, each ADDR_WIDTH+1 bits (extra wrap bit), incrementing modulo 2**(ADDR_WIDTH+1).
REQ-018 A write SHALL be accepted on a rising edge with wr_en=1 and full=0, and wr_bin SHALL then increment by 1.
REQ-019 A read SHALL be accepted on a rising edge with rd_en=1 and empty=0, and rd_bin SHALL then increment by 1.
REQ-020 Acceptance SHALL use the registered flags as they stand in the current cycle, not the next-state flags.
REQ-021 With wr_en and rd_en both set and the block neither full nor empty, both SHALL be accepted and count SHALL stay unchanged.
REQ-022 When full and both wr_en and rd_en are set, the read SHALL be accepted, the write SHALL be rejected, and overflow SHALL set.
REQ-023 When empty and both wr_en and rd_en are set, the write SHALL be accepted, the read SHALL be rejected, and underflow SHALL set.
REQ-024 wr_gray and rd_gray SHALL be registered as next_bin ^ (next_bin >> 1) and SHALL update on the same edge as their binary pointer, with exactly one bit changing per increment, including at wrap.
REQ-025 count SHALL be registered as (next_wr_bin - next_rd_bin) mod 2**(ADDR_WIDTH+1).
REQ-026 full SHALL be registered from next pointers: MSBs differ and lower ADDR_WIDTH bits equal, i.e. count==DEPTH.
REQ-027 empty SHALL be registered from next pointers: all bits equal, i.e. count==0.
REQ-028 almost_full SHALL be registered as next count >= AF_THRESH; almost_empty SHALL be registered as next count <= AE_THRESH.
REQ-029 All status outputs SHALL be valid on the edge after the causing operation, with one-cycle latency and no combinational path from wr_en/rd_en to any output.
REQ-030 overflow SHALL set on any cycle with wr_en=1 and full=1; underflow SHALL set on any cycle with rd_en=1 and empty=1; both SHALL stay set until clr or reset.
REQ-031 wr_ack SHALL be 1 for exactly the cycle after each accepted write, and rd_ack likewise for each accepted read.
REQ-032 clr=1 SHALL override wr_en and rd_en and SHALL load every register with its reset value on that edge.
REQ-033 Pointer wrap SHALL need no special handling: after 2**(ADDR_WIDTH+1) accepted writes, wr_bin SHALL return to 0.

Reset
REQ-034 On rst_n low, asynchronously and independent of clk: wr_bin=rd_bin=0, wr_gray=rd_gray=0, count=0, full=0, empty=1, almost_full=(AF_THRESH==0), almost_empty=1, overflow=underflow=0, wr_ack=rd_ack=0.
REQ-035 Reset asserted mid-operation SHALL discard all pointer state, with no partial update on the edge where rst_n rises.

Verification (ADDR_WIDTH=4, AF_THRESH=14, AE_THRESH=2)
REQ-036 Test: reset released -> empty=1, almost_empty=1, full=0, count=0, all pointers 0.
REQ-037 Test: 16 writes with wr_en held -> count goes 1..16; almost_empty drops after 3rd; almost_full rises after 14th; full=1 after 16th; wr_gray=11000; then 17th write -> pointers unchanged, overflow=1, no wr_ack.
REQ-038 Test: full, then wr_en=rd_en=1 for one cycle -> rd_ack=1, wr_ack=0, count=15, full=0, overflow=1.
REQ-039 Test: empty, rd_en=1 -> underflow=1, rd_bin stays 0; then wr_en=rd_en=1 -> count=1, only wr_ack pulses.
REQ-040 Test: 40 write/read pairs at steady count=5 -> pointers wrap through 31->0, every Gray transition changes exactly one bit, count stays 5.
REQ-041 Test: clr at count=9 with wr_en=1 -> next cycle count=0, empty=1, overflow/underflow=0, no wr_ack; separately, rst_n pulsed low between edges -> outputs reset immediately.
